// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the execute/memory boundary.
package pipeline_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } redirect_state_t;

endpackage

// File: rtl/ex_mem_stage_stage_reg.sv
// Pipeline register with synchronous clear (priority) and load enable.
module stage_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// E->M boundary: branch resolution, PC redirect / front-end flush, M-stage registers.
// Optional BRANCH_STATS_EN adds saturating BranchCount / TakenCount outputs.
module ex_mem_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     ALUoutE,
    input  logic                      ZeroE,
    input  logic [DATA_WIDTH-1:0]     WriteDataE,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [ADDR_WIDTH-1:0]     PCPlus4E,
    input  logic [ADDR_WIDTH-1:0]     PCTargetE,
    input  logic                      RegWriteE,
    input  logic                      MemWriteE,
    input  logic                      JumpE,
    input  logic                      BranchE,
    input  logic                      BranchNeE,
    input  logic                      ValidE,
    input  result_src_t               ResultSrcE,
    input  logic                      StallM,
    output logic                      PCSrcE,
    output logic [ADDR_WIDTH-1:0]     PCTargetOut,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [DATA_WIDTH-1:0]     ALUResultM,
    output logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [REG_ADDR_WIDTH-1:0] RdM,
    output logic [ADDR_WIDTH-1:0]     PCPlus4M,
    output logic                      RegWriteM,
    output logic                      MemWriteM,
    output logic                      ValidM,
    output result_src_t               ResultSrcM,
`ifdef BRANCH_STATS_EN
    output logic [31:0]               BranchCount,
    output logic [31:0]               TakenCount,
`endif
    output redirect_state_t           state_dbg
);

    // Handshake: an E instruction transfers into M on every edge where StallM=0;
    // ValidE=0 marks a bubble, and while StallM=1 both E (upstream) and M hold.
    localparam int DGRP_W = 2*DATA_WIDTH + REG_ADDR_WIDTH + ADDR_WIDTH + 2;

    redirect_state_t state, state_next;
    logic            taken, live, redirect, right_path;
    logic [DGRP_W-1:0] dgrp_q;
    logic [2:0]        cgrp_q;

    // BranchE wins when both branch flavours are set.
    assign taken      = JumpE | (BranchE & ZeroE) | (~BranchE & BranchNeE & ~ZeroE);
    assign live       = ValidE & ~StallM & (state == IDLE) & ~rst;
    assign redirect   = live & taken;
    assign right_path = (state == IDLE);

    assign PCSrcE      = redirect;
    assign FlushD      = redirect;
    assign FlushE      = redirect;
    assign PCTargetOut = PCTargetE;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (redirect) state_next = SQUASH;
            SQUASH:  if (!StallM)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath fields load unconditionally; only the control group is qualified.
    stage_reg #(.WIDTH(DGRP_W)) u_data_reg (
        .clk (clk),
        .clr (rst),
        .en  (~StallM),
        .d   ({ALUoutE, WriteDataE, RdE, PCPlus4E, ResultSrcE}),
        .q   (dgrp_q)
    );

    stage_reg #(.WIDTH(3)) u_ctrl_reg (
        .clk (clk),
        .clr (rst),
        .en  (~StallM),
        .d   ({ValidE & right_path, RegWriteE & right_path, MemWriteE & right_path}),
        .q   (cgrp_q)
    );

    assign {ALUResultM, WriteDataM, RdM, PCPlus4M} = dgrp_q[DGRP_W-1:2];
    assign ResultSrcM                        = result_src_t'(dgrp_q[1:0]);
    assign {ValidM, RegWriteM, MemWriteM}    = cgrp_q;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCount <= '0;
            TakenCount  <= '0;
        end else if (live && (BranchE || BranchNeE || JumpE)) begin
            if (BranchCount != 32'hFFFF_FFFF)         BranchCount <= BranchCount + 32'd1;
            if (taken && TakenCount != 32'hFFFF_FFFF) TakenCount  <= TakenCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage against a cycle-level reference model.
module tb_ex_mem_stage;
    import pipeline_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] ALUoutE, WriteDataE;
    logic          ZeroE;
    logic [RW-1:0] RdE;
    logic [AW-1:0] PCPlus4E, PCTargetE;
    logic RegWriteE, MemWriteE, JumpE, BranchE, BranchNeE, ValidE, StallM;
    result_src_t   ResultSrcE;
    logic          PCSrcE, FlushD, FlushE;
    logic [AW-1:0] PCTargetOut, PCPlus4M;
    logic [DW-1:0] ALUResultM, WriteDataM;
    logic [RW-1:0] RdM;
    logic          RegWriteM, MemWriteM, ValidM;
    result_src_t   ResultSrcM;
    redirect_state_t state_dbg;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCount, TakenCount;
`endif

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .ALUoutE(ALUoutE), .ZeroE(ZeroE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .BranchNeE(BranchNeE),
        .ValidE(ValidE), .ResultSrcE(ResultSrcE), .StallM(StallM), .PCSrcE(PCSrcE),
        .PCTargetOut(PCTargetOut), .FlushD(FlushD), .FlushE(FlushE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ValidM(ValidM), .ResultSrcM(ResultSrcM),
`ifdef BRANCH_STATS_EN
        .BranchCount(BranchCount), .TakenCount(TakenCount),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: "the instruction right after a redirect is wrong-path"
    bit            wrong_path;
    bit            m_valid, m_rw, m_mw, m_zero;
    logic [DW-1:0] m_alu, m_wd;
    logic [RW-1:0] m_rd;
    logic [AW-1:0] m_pc4;
    logic [1:0]    m_rs;
    logic [31:0]   n_branch, n_taken;
    logic          last_pcsrc;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic nop();
        rst = 0; StallM = 0; ValidE = 0;
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; BranchNeE = 0;
        ZeroE = 1'($urandom_range(0, 1));
        ALUoutE = $urandom; WriteDataE = $urandom; RdE = RW'($urandom);
        PCPlus4E = $urandom; PCTargetE = $urandom;
        ResultSrcE = result_src_t'($urandom_range(0, 2));
    endtask

    task automatic alu(input logic [RW-1:0] rd, input logic [DW-1:0] val);
        nop();
        ValidE = 1; RegWriteE = 1; RdE = rd; ALUoutE = val; ResultSrcE = RES_ALU;
    endtask

    task automatic br(input logic b, input logic bne, input logic j, input logic z,
                      input logic [AW-1:0] tgt);
        nop();
        ValidE = 1; BranchE = b; BranchNeE = bne; JumpE = j; ZeroE = z; PCTargetE = tgt;
        RegWriteE = j;
    endtask

    // one clock: combinational checks mid-cycle, model update at the edge, M checks after
    task automatic cycle();
        logic taken_m, live_m, redir_m, loaded;
        @(negedge clk);
        if (JumpE)        taken_m = 1'b1;
        else if (BranchE) taken_m = ZeroE;
        else              taken_m = BranchNeE & ~ZeroE;
        live_m  = ValidE & ~StallM & ~wrong_path & ~rst;
        redir_m = live_m & taken_m;
        last_pcsrc = PCSrcE;
        check("pcsrc", PCSrcE, redir_m);
        check("flushd", FlushD, redir_m);
        check("flushe", FlushE, redir_m);
        check("target", PCTargetOut, PCTargetE);
        @(posedge clk);
        loaded = 0;
        if (rst) begin
            {m_valid, m_rw, m_mw} = '0;
            m_alu = '0; m_wd = '0; m_rd = '0; m_pc4 = '0; m_rs = '0;
            wrong_path = 0; n_branch = 0; n_taken = 0; m_zero = 1;
            exp_q.delete();
        end else if (!StallM) begin
            m_valid = ValidE & ~wrong_path;
            m_rw    = RegWriteE & ~wrong_path;
            m_mw    = MemWriteE & ~wrong_path;
            m_alu = ALUoutE; m_wd = WriteDataE; m_rd = RdE; m_pc4 = PCPlus4E; m_rs = ResultSrcE;
            if (live_m && (BranchE || JumpE || BranchNeE)) begin
                if (n_branch != 32'hFFFF_FFFF)          n_branch++;
                if (taken_m && n_taken != 32'hFFFF_FFFF) n_taken++;
            end
            wrong_path = redir_m;
            m_zero = 0;
            if (m_valid) begin
                exp_q.push_back(ALUoutE);
                loaded = 1;
            end
        end
        #1;
        check("validm", ValidM, m_valid);
        check("regwritem", RegWriteM, m_rw);
        check("memwritem", MemWriteM, m_mw);
        check("state", state_dbg, wrong_path ? SQUASH : IDLE);
        if (m_valid || m_zero) begin
            check("writedatam", WriteDataM, m_wd);
            check("rdm", RdM, m_rd);
            check("pcplus4m", PCPlus4M, m_pc4);
            check("resultsrcm", ResultSrcM, m_rs);
            check("aluresultm", ALUResultM, m_alu);
        end
        if (loaded) check("alu_sb", ALUResultM, exp_q.pop_front());
`ifdef BRANCH_STATS_EN
        check("branchcount", BranchCount, n_branch);
        check("takencount", TakenCount, n_taken);
`endif
    endtask

    initial begin
        wrong_path = 0; m_zero = 0; n_branch = 0; n_taken = 0;
        {m_valid, m_rw, m_mw} = '0;
        m_alu = '0; m_wd = '0; m_rd = '0; m_pc4 = '0; m_rs = '0;
        nop(); rst = 1;
        cycle(); cycle();
        check("reset_validm", ValidM, 1'b0);
        check("reset_alu", ALUResultM, 32'h0);
        check("reset_state", state_dbg, IDLE);

        // ALU add reaches M one cycle later
        alu(5'd5, 32'h0000_0010);
        cycle();
        check("add_alu", ALUResultM, 32'h10);
        check("add_rd", RdM, 5'd5);
        check("add_rw", RegWriteM, 1'b1);
        check("add_pcsrc", last_pcsrc, 1'b0);

        // beq taken, following instruction squashed
        br(1, 0, 0, 1, 32'h100);
        cycle();
        check("beq_pcsrc", last_pcsrc, 1'b1);
        alu(5'd7, 32'h1234);
        cycle();
        check("beq_shadow_valid", ValidM, 1'b0);
        check("beq_shadow_rw", RegWriteM, 1'b0);

        // bne not taken; beq+bne with zero=0 is not taken (beq wins)
        br(0, 1, 0, 1, 32'h200);
        cycle();
        check("bne_nt", last_pcsrc, 1'b0);
        br(1, 1, 0, 0, 32'h300);
        cycle();
        check("both_nt", last_pcsrc, 1'b0);

        // stalled taken branch redirects only on release, once
        br(1, 0, 0, 1, 32'h400);
        StallM = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_nopcsrc", last_pcsrc, 1'b0);
        end
        StallM = 0;
        cycle();
        check("release_pcsrc", last_pcsrc, 1'b1);
        cycle();
        check("release_single", last_pcsrc, 1'b0);

        // reset during SQUASH, then a jump redirects normally
        br(0, 0, 1, 0, 32'h500);
        cycle();
        alu(5'd3, 32'hABCD);
        rst = 1;
        cycle();
        check("rst_sq_state", state_dbg, IDLE);
        check("rst_sq_valid", ValidM, 1'b0);
        check("rst_sq_rd", RdM, 5'd0);
        br(0, 0, 1, 0, 32'h600);
        cycle();
        check("post_rst_jump", last_pcsrc, 1'b1);
        nop(); cycle();

        // branch stats: 4 branches, 3 taken, the wrong-path one uncounted
        nop(); rst = 1; cycle();
        br(1, 0, 0, 1, 32'h700); cycle();
        br(1, 0, 0, 1, 32'h704); cycle();
        br(0, 1, 0, 1, 32'h708); cycle();
        br(0, 0, 1, 0, 32'h70C); cycle();
        nop(); cycle();
`ifdef BRANCH_STATS_EN
        check("stats_branch", BranchCount, 32'd3);
        check("stats_taken", TakenCount, 32'd2);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            nop();
            ValidE    = ($urandom_range(0, 9) < 8);
            BranchE   = ($urandom_range(0, 3) == 0);
            BranchNeE = ($urandom_range(0, 3) == 0);
            JumpE     = ($urandom_range(0, 7) == 0);
            RegWriteE = 1'($urandom_range(0, 1));
            MemWriteE = 1'($urandom_range(0, 1));
            StallM    = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
